product_accumulator: RTL and testbench

//  Downstream consumer of the shift-and-add multiplier's product stream. Sums LEN

---
 rtl/product_accumulator_pkg.sv | 18 +
 rtl/product_accumulator_if.sv | 30 +++
 rtl/product_accumulator_acc_sat_adder.sv | 31 +++
 rtl/product_accumulator.sv | 118 +++++++++++
 tb/tb_product_accumulator.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/product_accumulator_pkg.sv
// Shared types and constants for the product accumulator block.
// The saturating variant is selected with the MAC_ACC_SAT_EN macro (see acc_sat_adder).
package product_accumulator_pkg;

    localparam int unsigned PW_DEF   = 16;
    localparam int unsigned AW_DEF   = 24;
    localparam int unsigned CNTW_DEF = 8;

    // All-ones clamp value; consumers slice the low AW bits they need.
    localparam logic [63:0] SAT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/product_accumulator_if.sv
// Product-in / block-sum-out handshake bundle for product_accumulator.
// master: the side that produces products and consumes sums; slave: the accumulator.
interface product_accumulator_if
    import product_accumulator_pkg::*;
#(
    parameter int unsigned PW   = PW_DEF,
    parameter int unsigned AW   = AW_DEF,
    parameter int unsigned CNTW = CNTW_DEF
) ();

    logic [CNTW-1:0] len;
    logic            in_valid;
    logic            in_ready;
    logic [PW-1:0]   in_prod;
    logic            out_valid;
    logic            out_ready;
    logic [AW-1:0]   out_sum;
    logic            out_ovf;

    modport master (
        output len, in_valid, in_prod, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf
    );

    modport slave (
        input  len, in_valid, in_prod, out_ready,
        output in_ready, out_valid, out_sum, out_ovf
    );

endinterface

// File: rtl/product_accumulator_acc_sat_adder.sv
// acc_sat_adder: AW-bit accumulator plus zero-extended PW-bit product.
// Default: result wraps modulo 2^AW. With MAC_ACC_SAT_EN defined the result
// clamps to all-ones on a carry out.
module acc_sat_adder
    import product_accumulator_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned PW = PW_DEF
) (
    input  logic [AW-1:0] acc,
    input  logic [PW-1:0] prod,
    output logic [AW-1:0] sum,
    output logic          carry
);

    logic [AW:0] wide;

    // AW+1-bit add; the top bit is the overflow carry. Once clamped, any
    // further nonzero product carries again and a zero product leaves the
    // all-ones value untouched, so the clamp persists without extra state.
    always_comb begin
        wide  = {1'b0, acc} + {{(AW + 1 - PW){1'b0}}, prod};
        carry = wide[AW];
`ifdef MAC_ACC_SAT_EN
        sum   = carry ? SAT_MAX[AW-1:0] : wide[AW-1:0];
`else
        sum   = wide[AW-1:0];
`endif
    end

endmodule

// File: rtl/product_accumulator.sv
// product_accumulator: sums LEN consecutive PW-bit products into an AW-bit
// block sum and presents it on a valid/ready port. Optional macro
// MAC_ACC_SAT_EN makes the accumulator saturate instead of wrapping.
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter int unsigned PW   = PW_DEF,
    parameter int unsigned AW   = AW_DEF,
    parameter int unsigned CNTW = CNTW_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    product_accumulator_if.slave  bus
);

    state_t          state_q, state_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [CNTW-1:0] len_q, len_d;
    logic            ovf_q, ovf_d;

    logic            in_ready;
    logic            beat;
    logic [CNTW-1:0] cnt_inc;
    logic [CNTW-1:0] len_eff;
    logic [AW-1:0]   add_sum;
    logic            add_carry;

    acc_sat_adder #(
        .AW (AW),
        .PW (PW)
    ) u_adder (
        .acc   (acc_q),
        .prod  (bus.in_prod),
        .sum   (add_sum),
        .carry (add_carry)
    );

    // Handshake qualifiers and derived counter/length values.
    always_comb begin
        in_ready = (state_q != HOLD) && !clear;
        beat     = bus.in_valid && in_ready;
        cnt_inc  = cnt_q + CNTW'(1);
        len_eff  = (bus.len == '0) ? CNTW'(1) : bus.len;
    end

    // Next-state and datapath update; clear overrides every other input.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        ovf_d   = ovf_q;
        if (clear) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (beat) begin
                        len_d   = len_eff;
                        acc_d   = {{(AW - PW){1'b0}}, bus.in_prod};
                        cnt_d   = CNTW'(1);
                        ovf_d   = 1'b0;
                        state_d = (len_eff == CNTW'(1)) ? HOLD : ACC;
                    end
                end
                ACC: begin
                    if (beat) begin
                        acc_d = add_sum;
                        ovf_d = ovf_q | add_carry;
                        cnt_d = cnt_inc;
                        if (cnt_inc == len_q) begin
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
        end
    end

    // Result port: the accumulator is held unchanged throughout HOLD.
    always_comb begin
        bus.in_ready  = in_ready;
        bus.out_valid = (state_q == HOLD);
        bus.out_sum   = acc_q;
        bus.out_ovf   = ovf_q;
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench for product_accumulator: two instances (AW=24 and AW=17)
// receive identical stimulus; expected block sums come from plain arithmetic.
module tb_product_accumulator;

    typedef struct {
        logic [63:0] sum_a;
        logic        ovf_a;
        logic [63:0] sum_b;
        logic        ovf_b;
        int          rdy;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear_s;
    logic [7:0]  len_s;
    logic        in_valid_s;
    logic [15:0] in_prod_s;
    logic        out_ready_s;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int or_mode = 0;
    int last_cyc = 0;

    exp_t        sb[$];
    logic [15:0] prods[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    product_accumulator_if #(.PW(16), .AW(24), .CNTW(8)) bus_a ();
    product_accumulator_if #(.PW(16), .AW(17), .CNTW(8)) bus_b ();

    assign bus_a.len       = len_s;
    assign bus_a.in_valid  = in_valid_s;
    assign bus_a.in_prod   = in_prod_s;
    assign bus_a.out_ready = out_ready_s;
    assign bus_b.len       = len_s;
    assign bus_b.in_valid  = in_valid_s;
    assign bus_b.in_prod   = in_prod_s;
    assign bus_b.out_ready = out_ready_s;

    product_accumulator #(.PW(16), .AW(24), .CNTW(8)) dut_a (
        .clk   (clk),
        .rst   (rst),
        .clear (clear_s),
        .bus   (bus_a.slave)
    );

    product_accumulator #(.PW(16), .AW(17), .CNTW(8)) dut_b (
        .clk   (clk),
        .rst   (rst),
        .clear (clear_s),
        .bus   (bus_b.slave)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: a block sum is the plain sum of its products; it either
    // wraps modulo 2^aw or clamps at 2^aw-1, and ovf flags the excess.
    function automatic void model(input int unsigned aw, input longint unsigned tot,
                                  output logic [63:0] s, output logic o);
        longint unsigned maxv;
        maxv = (64'd1 << aw) - 64'd1;
        o = (tot > maxv);
`ifdef MAC_ACC_SAT_EN
        s = o ? maxv : tot;
`else
        s = tot & maxv;
`endif
    endfunction

    // Consumer-side ready: 0 = always ready, 1 = random, 2 = stalled.
    initial begin
        out_ready_s = 1'b1;
        forever begin
            @(negedge clk);
            case (or_mode)
                0:       out_ready_s = 1'b1;
                1:       out_ready_s = ($urandom_range(0, 2) != 0);
                default: out_ready_s = 1'b0;
            endcase
        end
    end

    // Monitor: samples just before each rising edge.
    initial begin
        bit exp_v;
        forever begin
            @(negedge clk);
            #4;
            exp_v = (sb.size() > 0) && (cyc >= sb[0].rdy);
            chk("a_out_valid", {63'd0, bus_a.out_valid}, {63'd0, exp_v});
            chk("b_out_valid", {63'd0, bus_b.out_valid}, {63'd0, exp_v});
            if (exp_v) begin
                chk("a_out_sum", {40'd0, bus_a.out_sum}, sb[0].sum_a);
                chk("a_out_ovf", {63'd0, bus_a.out_ovf}, {63'd0, sb[0].ovf_a});
                chk("b_out_sum", {47'd0, bus_b.out_sum}, sb[0].sum_b);
                chk("b_out_ovf", {63'd0, bus_b.out_ovf}, {63'd0, sb[0].ovf_b});
                chk("a_in_ready_hold", {63'd0, bus_a.in_ready}, 64'd0);
                chk("b_in_ready_hold", {63'd0, bus_b.in_ready}, 64'd0);
                if (out_ready_s) void'(sb.pop_front());
            end else begin
                chk("a_in_ready", {63'd0, bus_a.in_ready}, {63'd0, !clear_s});
                chk("b_in_ready", {63'd0, bus_b.in_ready}, {63'd0, !clear_s});
            end
        end
    end

    task automatic do_beat(input logic [15:0] p, input logic [7:0] l, output bit ok);
        int guard;
        guard = 0;
        ok = 1'b1;
        @(negedge clk);
        len_s      = l;
        in_valid_s = 1'b1;
        in_prod_s  = p;
        #1;
        while (!bus_a.in_ready && guard < 300) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (guard >= 300) begin
            total++;
            bad++;
            $display("FAIL beat_timeout: in_ready stuck low got 0 expected 1 (cycle %0d)", cyc);
            in_valid_s = 1'b0;
            ok = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid_s = 1'b0;
        last_cyc   = cyc;
    endtask

    task automatic send_block(input int unsigned l, input bit push, input bit gaps);
        longint unsigned tot;
        exp_t e;
        bit ok;
        tot = 0;
        for (int i = 0; i < prods.size(); i++) begin
            if (gaps && i > 0 && $urandom_range(0, 3) == 0) @(negedge clk);
            do_beat(prods[i], (i == 0) ? 8'(l) : 8'($urandom_range(0, 255)), ok);
            if (!ok) return;
            tot += longint'(prods[i]);
        end
        if (push) begin
            model(24, tot, e.sum_a, e.ovf_a);
            model(17, tot, e.sum_b, e.ovf_b);
            e.rdy = last_cyc;
            sb.push_back(e);
        end
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: pending got %0d expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        total++;
        bad++;
        $display("FAIL watchdog: cycle got %0d expected completion", cyc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int unsigned l;
        int unsigned leff;
        int unsigned kind;

        rst        = 1'b0;
        clear_s    = 1'b0;
        len_s      = '0;
        in_valid_s = 1'b0;
        in_prod_s  = '0;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_a_out_valid", {63'd0, bus_a.out_valid}, 64'd0);
        chk("rst_a_out_sum", {40'd0, bus_a.out_sum}, 64'd0);
        chk("rst_a_out_ovf", {63'd0, bus_a.out_ovf}, 64'd0);
        chk("rst_b_out_sum", {47'd0, bus_b.out_sum}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rel_a_in_ready", {63'd0, bus_a.in_ready}, 64'd1);
        chk("rel_b_in_ready", {63'd0, bus_b.in_ready}, 64'd1);

        // Four products back to back.
        prods = '{16'd10, 16'd20, 16'd30, 16'd40};
        send_block(4, 1'b1, 1'b0);

        // Zero length acts as a single-product block.
        prods = '{16'h00FF};
        send_block(0, 1'b1, 1'b0);

        // Result stalled for five cycles while the next block waits.
        wait_drain();
        or_mode = 2;
        prods = '{16'd1, 16'd2, 16'd3};
        send_block(3, 1'b1, 1'b0);
        fork
            begin
                repeat (5) @(negedge clk);
                #2;
                or_mode = 0;
            end
        join_none
        prods = '{16'd4, 16'd5};
        send_block(2, 1'b1, 1'b0);

        // Three maximal products: wraps/clamps on the 17-bit instance.
        prods = '{16'hFFFF, 16'hFFFF, 16'hFFFF};
        send_block(3, 1'b1, 1'b0);

        // Abort a partial block; the concurrent beat must be refused.
        wait_drain();
        prods = '{16'd1, 16'd2};
        send_block(5, 1'b0, 1'b0);
        @(negedge clk);
        clear_s    = 1'b1;
        in_valid_s = 1'b1;
        in_prod_s  = 16'h1234;
        len_s      = 8'd5;
        #1;
        chk("clr_a_in_ready", {63'd0, bus_a.in_ready}, 64'd0);
        chk("clr_b_in_ready", {63'd0, bus_b.in_ready}, 64'd0);
        @(posedge clk);
        #1;
        clear_s    = 1'b0;
        in_valid_s = 1'b0;
        prods = '{16'd7, 16'd8};
        send_block(2, 1'b1, 1'b0);

        // Reset in the middle of a block.
        wait_drain();
        prods = '{16'd1, 16'd2, 16'd3};
        send_block(6, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_a_out_valid", {63'd0, bus_a.out_valid}, 64'd0);
        chk("mid_rst_a_out_sum", {40'd0, bus_a.out_sum}, 64'd0);
        chk("mid_rst_b_out_sum", {47'd0, bus_b.out_sum}, 64'd0);
        chk("mid_rst_a_out_ovf", {63'd0, bus_a.out_ovf}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        prods = '{16'd5, 16'd6};
        send_block(2, 1'b1, 1'b0);

        // Random blocks with gaps, random backpressure and mid-block len noise.
        wait_drain();
        or_mode = 1;
        for (int b = 0; b < 40; b++) begin
            l    = $urandom_range(0, 10);
            leff = (l == 0) ? 1 : l;
            kind = $urandom_range(0, 3);
            prods.delete();
            for (int i = 0; i < int'(leff); i++) begin
                if (kind == 0) prods.push_back(16'hFFFF);
                else           prods.push_back(16'($urandom));
            end
            send_block(l, 1'b1, 1'b1);
        end
        or_mode = 0;
        wait_drain();
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
